// File: rtl/riscv_instr_aligner.sv
// rtl/riscv_instr_aligner.sv - realigns 32-bit fetch words into one RV32/RVC instruction per cycle
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch_valid/ready   fetch word handshake (fetch_ready is combinational)
//   fetch_data/pc       4-byte-aligned fetch word and its byte address
//   flush/flush_pc      discard buffered state, restart at flush_pc (bit[1] = start halfword)
//   out_valid/ready     decoder handshake
//   out_instr/pc        instruction (RVC zero-extended) and its address
//   out_compressed      instruction is a 16-bit RVC encoding
module riscv_instr_aligner #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_valid,
  output logic                 fetch_ready,
  input  logic [31:0]          fetch_data,
  input  logic [DataWidth-1:0] fetch_pc,
  input  logic                 flush,
  input  logic [DataWidth-1:0] flush_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [DataWidth-1:0] out_pc,
  output logic                 out_compressed
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t               state;
  logic [15:0]          hb;
  logic [DataWidth-1:0] hb_pc;
  logic                 skip_lo;

  logic                 advance;
  logic                 hb_is_wide;
  logic                 fetch_fire;
  logic [DataWidth-1:0] fetch_pc_hi;

  assign advance     = !out_valid || out_ready;
  // A pending halfword with low bits 11 is the first half of a 32-bit instruction.
  assign hb_is_wide  = (hb[1:0] == 2'b11);
  // rst_n gates the handshake so nothing is consumed while reset is asserted.
  assign fetch_ready = rst_n && advance && !flush && ((state == EMPTY) || hb_is_wide);
  assign fetch_fire  = fetch_valid && fetch_ready;
  assign fetch_pc_hi = fetch_pc + DataWidth'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= EMPTY;
      hb             <= 16'h0;
      hb_pc          <= '0;
      skip_lo        <= 1'b0;
      out_valid      <= 1'b0;
      out_instr      <= 32'h0;
      out_pc         <= '0;
      out_compressed <= 1'b0;
    end else if (flush) begin
      // Flush overrides everything, including a simultaneous output handoff.
      out_valid <= 1'b0;
      state     <= EMPTY;
      skip_lo   <= flush_pc[1];
    end else if (advance) begin
      case (state)
        EMPTY: begin
          if (fetch_fire) begin
            if (skip_lo) begin
              // Redirect landed on the upper halfword: drop the lower one.
              hb        <= fetch_data[31:16];
              hb_pc     <= fetch_pc_hi;
              skip_lo   <= 1'b0;
              state     <= HALF;
              out_valid <= 1'b0;
            end else if (fetch_data[1:0] != 2'b11) begin
              out_valid      <= 1'b1;
              out_instr      <= {16'h0, fetch_data[15:0]};
              out_pc         <= fetch_pc;
              out_compressed <= 1'b1;
              hb             <= fetch_data[31:16];
              hb_pc          <= fetch_pc_hi;
              state          <= HALF;
            end else begin
              out_valid      <= 1'b1;
              out_instr      <= fetch_data;
              out_pc         <= fetch_pc;
              out_compressed <= 1'b0;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        HALF: begin
          if (!hb_is_wide) begin
            // Buffered RVC needs no new fetch word.
            out_valid      <= 1'b1;
            out_instr      <= {16'h0, hb};
            out_pc         <= hb_pc;
            out_compressed <= 1'b1;
            state          <= EMPTY;
          end else if (fetch_fire) begin
            // Straddling 32-bit instruction; upper half of the word stays buffered.
            out_valid      <= 1'b1;
            out_instr      <= {fetch_data[15:0], hb};
            out_pc         <= hb_pc;
            out_compressed <= 1'b0;
            hb             <= fetch_data[31:16];
            hb_pc          <= fetch_pc_hi;
          end else begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// tb/tb_riscv_instr_aligner.sv - directed self-checking bench for riscv_instr_aligner
module tb_riscv_instr_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;

  int total = 0;
  int bad   = 0;

  riscv_instr_aligner #(.DataWidth(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_data     (fetch_data),
    .fetch_pc       (fetch_pc),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_compressed (out_compressed)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks happen 1ns after that.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] d, input logic [31:0] pc);
    fetch_valid = fv;
    fetch_data  = d;
    fetch_pc    = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = 32'h0; fetch_pc = 32'h0;
    flush = 1'b0; flush_pc = 32'h0; out_ready = 1'b1;
    repeat (2) cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    total++; if (out_compressed !== 1'b0) begin bad++; $display("FAIL reset_comp got=%b exp=0", out_compressed); end
    fetch_valid = 1'b1; #1;
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL reset_fready got=%b exp=0", fetch_ready); end
    fetch_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_two_32bit();
    drive(1'b1, 32'h00000013, 32'h0);
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL w32_fready0 got=%b exp=1", fetch_ready); end
    cyc();
    drive(1'b1, 32'h00100093, 32'h4);
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL w32_fready1 got=%b exp=1", fetch_ready); end
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00000013, 32'h0, 1'b0})
      begin bad++; $display("FAIL w32_out0 got=%b %h %h %b exp=1 00000013 00000000 0", out_valid, out_instr, out_pc, out_compressed); end
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00100093, 32'h4, 1'b0})
      begin bad++; $display("FAIL w32_out1 got=%b %h %h %b exp=1 00100093 00000004 0", out_valid, out_instr, out_pc, out_compressed); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL w32_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_two_rvc(input logic [31:0] base);
    drive(1'b1, 32'h00010001, base);
    cyc();
    drive(1'b1, 32'h00000013, base + 32'h4);
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00000001, base, 1'b1})
      begin bad++; $display("FAIL rvc_out0 got=%b %h %h %b exp=1 00000001 %h 1", out_valid, out_instr, out_pc, out_compressed, base); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL rvc_fready_half got=%b exp=0", fetch_ready); end
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00000001, base + 32'h2, 1'b1})
      begin bad++; $display("FAIL rvc_out1 got=%b %h %h %b exp=1 00000001 %h 1", out_valid, out_instr, out_pc, out_compressed, base + 32'h2); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL rvc_end_empty got=%b exp=1", fetch_ready); end
    cyc();
  endtask

  task automatic test_straddle_backpressure();
    drive(1'b1, 32'h00930001, 32'h10);
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 32'h00010010, 32'h14);
    for (int i = 0; i < 3; i++) begin
      total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00000001, 32'h10, 1'b1})
        begin bad++; $display("FAIL bp_hold%0d got=%b %h %h %b exp=1 00000001 00000010 1", i, out_valid, out_instr, out_pc, out_compressed); end
      total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL bp_fready%0d got=%b exp=0", i, fetch_ready); end
      cyc();
    end
    out_ready = 1'b1; #1;
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL bp_release_fready got=%b exp=1", fetch_ready); end
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00100093, 32'h12, 1'b0})
      begin bad++; $display("FAIL straddle_out got=%b %h %h %b exp=1 00100093 00000012 0", out_valid, out_instr, out_pc, out_compressed); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL straddle_fready got=%b exp=0", fetch_ready); end
    cyc();
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00000001, 32'h16, 1'b1})
      begin bad++; $display("FAIL straddle_tail got=%b %h %h %b exp=1 00000001 00000016 1", out_valid, out_instr, out_pc, out_compressed); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL straddle_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_odd_flush();
    drive(1'b1, 32'h00010001, 32'h1C);
    cyc();
    flush = 1'b1; flush_pc = 32'h22;
    drive(1'b1, 32'h00000013, 32'h20);
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL flush_fready got=%b exp=0", fetch_ready); end
    cyc();
    flush = 1'b0;
    drive(1'b1, 32'h00010013, 32'h20);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL flush_restart_fready got=%b exp=1", fetch_ready); end
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%b exp=0", out_valid); end
    cyc();
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00000001, 32'h22, 1'b1})
      begin bad++; $display("FAIL flush_out got=%b %h %h %b exp=1 00000001 00000022 1", out_valid, out_instr, out_pc, out_compressed); end
    cyc();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h00010001, 32'h30);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL areset_instr got=%h exp=0", out_instr); end
    cyc();
    rst_n = 1'b1;
    drive(1'b1, 32'h00000013, 32'h0);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    total++; if ({out_valid, out_instr, out_pc, out_compressed} !== {1'b1, 32'h00000013, 32'h0, 1'b0})
      begin bad++; $display("FAIL areset_restart got=%b %h %h %b exp=1 00000013 00000000 0", out_valid, out_instr, out_pc, out_compressed); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_two_32bit();
    test_two_rvc(32'h8);
    test_straddle_backpressure();
    test_odd_flush();
    test_two_rvc(32'hFFFFFFFC);
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
